sobel_window: RTL and testbench

Streaming 5×5 window generator that sits directly upstream of the 5×5 Sobel edge stage. It accepts raster-order 8-bit grayscale pixels one per valid cycle and buffers four previous lines. For every pixel whose 5×5 neighbourhood is fully inside the frame, it presents the neighbourhood as a packed 200-bit word, in exactly the layout the Sobel stage slices into z0..z24.

---
 rtl/sobel_window_pkg.sv | 14 +
 rtl/sobel_window_line_buf.sv | 23 ++
 rtl/sobel_window.sv | 85 ++++++++
 tb/tb_sobel_window.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_window_pkg.sv
// Shared constants and window layout for the 5x5 window generator and the
// Sobel stage that consumes it.
package sobel_window_pkg;

  localparam int PIX_W = 8;
  localparam int KSIZE = 5;
  localparam int MAT_W = KSIZE * KSIZE * PIX_W;

  // MSB position of element z(5*row+col) inside the packed window word.
  function automatic int unsigned z_off(input int unsigned row, input int unsigned col);
    return MAT_W - 1 - PIX_W * (KSIZE * row + col);
  endfunction

endpackage

// File: rtl/sobel_window_line_buf.sv
// One line of pixel storage: combinational read, synchronous write.
// Reads return the old word in the cycle it is overwritten.
module sobel_window_line_buf #(
  parameter int LINE_W = 640,
  parameter int DATA_W = 8,
  localparam int AW    = $clog2(LINE_W)
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [LINE_W];

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sobel_window.sv
// Streaming 5x5 window generator: four chained line buffers feed a 5x5
// shift array whose packed contents drive the Sobel stage directly.
module sobel_window
  import sobel_window_pkg::*;
#(
  parameter int LINE_W = 640
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  output logic [MAT_W-1:0] matrix_out,
  output logic             window_valid
);

  localparam int AW   = $clog2(LINE_W);
  localparam int NBUF = KSIZE - 1;

  logic [AW-1:0] r_col, w_col;
  logic [2:0]    r_row, w_row;
  logic          r_win_vld;

  logic [NBUF-1:0][PIX_W-1:0] w_rd, w_wd;
  logic [KSIZE-1:0][PIX_W-1:0] w_newcol;

  // Index [0][0] lands in the MSBs, so the array packs straight into z0..z24.
  logic [0:KSIZE-1][0:KSIZE-1][PIX_W-1:0] r_win;

  // sof takes effect on the pixel it arrives with.
  assign w_col = sof ? '0 : r_col;
  assign w_row = sof ? '0 : r_row;

  // Each buffer ages by one row on accept: L0 <- pixel, Ln <- old L(n-1).
  assign w_wd = {w_rd[NBUF-2:0], pix_in};

  for (genvar g = 0; g < NBUF; g++) begin : g_lb
    sobel_window_line_buf #(
      .LINE_W (LINE_W),
      .DATA_W (PIX_W)
    ) u_lb (
      .clock   (clock),
      .i_we    (pix_valid),
      .i_addr  (w_col),
      .i_wdata (w_wd[g]),
      .o_rdata (w_rd[g])
    );
  end

  // Top row of the new column is the oldest line (L3), bottom is pix_in.
  always_comb begin
    w_newcol = '0;
    for (int i = 0; i < NBUF; i++) w_newcol[i] = w_rd[NBUF-1-i];
    w_newcol[KSIZE-1] = pix_in;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_col     <= '0;
      r_row     <= '0;
      r_win     <= '0;
      r_win_vld <= 1'b0;
    end else if (pix_valid) begin
      if (w_col == AW'(LINE_W - 1)) begin
        r_col <= '0;
        r_row <= (w_row == 3'd4) ? 3'd4 : w_row + 3'd1;
      end else begin
        r_col <= w_col + AW'(1);
        r_row <= w_row;
      end
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE - 1; c++) r_win[r][c] <= r_win[r][c+1];
        r_win[r][KSIZE-1] <= w_newcol[r];
      end
      // Gating on both counters hides stale buffer rows and carried-over columns.
      r_win_vld <= (w_row >= 3'd4) && (w_col >= AW'(4));
    end else begin
      r_win_vld <= 1'b0;
    end
  end

  assign matrix_out   = r_win;
  assign window_valid = r_win_vld;

endmodule

// File: tb/tb_sobel_window.sv
// Scoreboard bench for sobel_window: a frame-image model predicts each 5x5
// window as pixels are driven; a negedge monitor pops and compares.
module tb_sobel_window;

  localparam int LW = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   pix_in = '0;
  logic         pix_valid = 1'b0;
  logic         sof = 1'b0;
  logic [199:0] matrix_out;
  logic         window_valid;

  always #5 clock = ~clock;

  sobel_window #(.LINE_W(LW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pix_in       (pix_in),
    .pix_valid    (pix_valid),
    .sof          (sof),
    .matrix_out   (matrix_out),
    .window_valid (window_valid)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 0;
  bit exp_vld = 0;
  int m_col = 0;
  int m_row = 0;
  logic [7:0]   img [64][LW];
  logic [199:0] sb [$];

  // kind 0: r*16+c, 1: all 0xFF, 2: all 0x00, 3: 0x80+r*16+c
  function automatic logic [7:0] pv(input int r, input int c, input int kind);
    case (kind)
      1:       return 8'hFF;
      2:       return 8'h00;
      3:       return 8'(128 + r * 16 + c);
      default: return 8'(r * 16 + c);
    endcase
  endfunction

  // Drive one cycle; the model tracks logical (row,col) since the last sof/reset.
  task automatic step(input logic [7:0] p, input bit v, input bit s, input bit rst);
    logic [0:4][0:4][7:0] e;
    pix_in = p; pix_valid = v; sof = s; reset_n = !rst;
    @(posedge clock);
    if (rst) begin
      m_col = 0; m_row = 0; exp_vld = 0;
    end else if (v) begin
      if (s) begin m_col = 0; m_row = 0; end
      img[m_row][m_col] = p;
      exp_vld = (m_row >= 4) && (m_col >= 4);
      if (exp_vld) begin
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            e[i][j] = img[m_row-4+i][m_col-4+j];
        sb.push_back(e);
      end
      m_col++;
      if (m_col == LW) begin m_col = 0; m_row++; end
    end else begin
      exp_vld = 0;
    end
    #1;
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      n_chk++;
      if (exp_vld) begin
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_empty: window expected but queue empty at %0t", $time);
        end else begin
          logic [199:0] e;
          e = sb.pop_front();
          if (window_valid !== 1'b1 || matrix_out !== e) begin
            n_fail++;
            $display("FAIL window: valid=%b data=%h, required valid=1 data=%h at %0t",
                     window_valid, matrix_out, e, $time);
          end
        end
      end else if (window_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL spurious_valid: window_valid=%b, required 0 at %0t", window_valid, $time);
      end
    end
  end

  task automatic test_reset();
    step(8'h00, 0, 0, 1);
    step(8'h00, 0, 0, 1);
    n_chk++;
    if (matrix_out !== '0 || window_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: matrix=%h valid=%b, required 0/0", matrix_out, window_valid);
    end
    mon_en = 1;
  endtask

  task automatic test_basic();
    int cnt4 = 0, cnt5 = 0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < LW; c++) begin
        step(pv(r, c, 0), 1, (r == 0 && c == 0), 0);
        if (window_valid === 1'b1) begin
          if (r == 4) cnt4++;
          if (r == 5) cnt5++;
        end
        if (r == 4 && c == 4) begin
          n_chk++;
          if (window_valid !== 1'b1 || matrix_out[199:192] !== 8'h00 || matrix_out[167:160] !== 8'h04 ||
              matrix_out[103:96] !== 8'h22 || matrix_out[39:32] !== 8'h40 || matrix_out[7:0] !== 8'h44) begin
            n_fail++;
            $display("FAIL first_window: valid=%b z0=%h z4=%h z12=%h z20=%h z24=%h, required 1 00 04 22 40 44",
                     window_valid, matrix_out[199:192], matrix_out[167:160], matrix_out[103:96],
                     matrix_out[39:32], matrix_out[7:0]);
          end
        end
        if (r == 5 && c < 4) begin
          n_chk++;
          if (window_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL line_wrap_gate: col %0d valid=%b, required 0", c, window_valid);
          end
        end
        if (r == 5 && c == 4) begin
          n_chk++;
          if (window_valid !== 1'b1 || matrix_out[199:192] !== 8'h10 || matrix_out[7:0] !== 8'h54) begin
            n_fail++;
            $display("FAIL wrap_window: valid=%b z0=%h z24=%h, required 1 10 54",
                     window_valid, matrix_out[199:192], matrix_out[7:0]);
          end
        end
      end
    end
    n_chk++;
    if (cnt4 != 4 || cnt5 != 4) begin
      n_fail++;
      $display("FAIL valid_count: row4=%0d row5=%0d, required 4 and 4", cnt4, cnt5);
    end
  endtask

  task automatic test_gaps();
    int cnt = 0;
    logic [199:0] held;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < LW; c++) begin
        step(pv(r, c, 0), 1, (r == 0 && c == 0), 0);
        if (window_valid === 1'b1) cnt++;
        held = matrix_out;
        step(8'hA5, 0, 1, 0);
        n_chk++;
        if (matrix_out !== held || window_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_hold: matrix=%h valid=%b, required %h and 0", matrix_out, window_valid, held);
        end
      end
    end
    n_chk++;
    if (cnt != 8) begin
      n_fail++;
      $display("FAIL gap_count: %0d windows, required 8", cnt);
    end
  endtask

  task automatic test_sof_mid();
    int early = 0;
    for (int k = 0; k < 5 * LW + 2; k++)
      step(pv(k / LW, k % LW, 0), 1, (k == 0), 0);
    for (int k = 0; k < 5 * LW; k++) begin
      step(pv(k / LW, k % LW, 3), 1, (k == 0), 0);
      if (k < 4 * LW + 4 && window_valid === 1'b1) early++;
      if (k == 4 * LW + 4) begin
        n_chk++;
        if (window_valid !== 1'b1 || matrix_out[7:0] !== 8'hC4 || matrix_out[199:192] !== 8'h80) begin
          n_fail++;
          $display("FAIL sof_restart_window: valid=%b z0=%h z24=%h, required 1 80 c4",
                   window_valid, matrix_out[199:192], matrix_out[7:0]);
        end
      end
    end
    n_chk++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL sof_restart_gate: %0d early windows, required 0", early);
    end
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    bit seen = 0;
    for (int k = 0; k < 4 * LW + 6; k++)
      step(pv(k / LW, k % LW, 0), 1, (k == 0), 0);
    step(pv(4, 6, 0), 1, 0, 1);
    n_chk++;
    if (matrix_out !== '0 || window_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: matrix=%h valid=%b, required 0/0", matrix_out, window_valid);
    end
    // Continue the raster with no sof; the window on the 37th accept is the first.
    for (int k = 4 * LW + 7; k < 4 * LW + 7 + 60 && !seen; k++) begin
      step(pv(k / LW, k % LW, 0), 1, 0, 0);
      if (window_valid === 1'b1) seen = 1;
      else acc++;
    end
    n_chk++;
    if (!seen || acc != 36) begin
      n_fail++;
      $display("FAIL reset_mid_latency: seen=%0d accepts_before=%0d, required 1 and 36", seen, acc);
    end
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    for (int k = 0; k < 6 * LW; k++)
      step(pv(k / LW, k % LW, 1), 1, (k == 0), 0);
    for (int k = 0; k < 6 * LW; k++) begin
      step(pv(k / LW, k % LW, 2), 1, (k == 0), 0);
      if (window_valid === 1'b1) begin
        cnt++;
        n_chk++;
        if (matrix_out !== '0) begin
          n_fail++;
          $display("FAIL stale_leak: matrix=%h, required all zero", matrix_out);
        end
      end
    end
    n_chk++;
    if (cnt != 8) begin
      n_fail++;
      $display("FAIL frame2_count: %0d windows, required 8", cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_sof_mid();
    test_reset_mid();
    test_back_to_back();
    step(8'h00, 0, 0, 0);
    step(8'h00, 0, 0, 0);
    mon_en = 0;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d windows never produced, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
